// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sys_ctrl_pkg
//  Description : Shared definitions for the system controller halves
//                (sys_ctrl_rec and sys_ctrl_send). Holds the command
//                opcodes, the fixed operand addresses and the state
//                encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package sys_ctrl_pkg;

    // First byte of every command frame
    localparam logic [7:0] CMD_WR      = 8'hAA;  // AA, addr, data
    localparam logic [7:0] CMD_RD      = 8'hBB;  // BB, addr
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // CC, A, B, fun
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // DD, fun

    // Register-file locations that hold the ALU operands
    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    // Receive-side FSM encoding
    typedef enum logic [2:0] {
        REC_IDLE     = 3'd0,
        REC_WR_ADDR  = 3'd1,
        REC_WR_DATA  = 3'd2,
        REC_RD_ADDR  = 3'd3,
        REC_OP_A     = 3'd4,
        REC_OP_B     = 3'd5,
        REC_ALU_FUN  = 3'd6,
        REC_ALU_WAIT = 3'd7
    } rec_state_e;

    // Send-side FSM encoding (used by sys_ctrl_send)
    typedef enum logic [2:0] {
        SEND_IDLE     = 3'd0,
        SEND_RD_DATA  = 3'd1,
        SEND_ALU_LSB  = 3'd2,
        SEND_ALU_MSB  = 3'd3,
        SEND_ALU_DONE = 3'd4
    } send_state_e;

endpackage : sys_ctrl_pkg
`default_nettype wire

// File: rtl/sys_ctrl_rec_if.sv
`default_nettype none
// ============================================================================
//  Module      : sys_ctrl_rec_if
//  Description : Bundle between the UART RX / sys_ctrl_send side and the
//                register file / ALU strobes of sys_ctrl_rec. The slave
//                modport is the receiver itself; the master modport is the
//                surrounding environment that feeds bytes and consumes
//                the strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sys_ctrl_rec_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);

    // Byte stream and send-side completion
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  alu_out_done;

    // Register file / ALU control
    logic [ADDR_WIDTH-1:0] Address;
    logic                  WrEn;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  RdEn;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  CLK_EN;
    logic                  sys_ctrl_send_en;

    modport slave (
        input  RX_P_DATA,
        input  RX_D_VLD,
        input  alu_out_done,
        output Address,
        output WrEn,
        output WrData,
        output RdEn,
        output ALU_EN,
        output ALU_FUN,
        output CLK_EN,
        output sys_ctrl_send_en
    );

    modport master (
        output RX_P_DATA,
        output RX_D_VLD,
        output alu_out_done,
        input  Address,
        input  WrEn,
        input  WrData,
        input  RdEn,
        input  ALU_EN,
        input  ALU_FUN,
        input  CLK_EN,
        input  sys_ctrl_send_en
    );

endinterface : sys_ctrl_rec_if
`default_nettype wire

// File: rtl/sys_ctrl_rec.sv
`default_nettype none
// ============================================================================
//  Module      : sys_ctrl_rec
//  Description : Command receiver of the system controller. Parses the
//                RX byte stream into register write, register read and
//                ALU commands, drives the register-file / ALU strobes and
//                kicks sys_ctrl_send whenever a response byte will follow.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_ctrl_rec
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic           CLK,
    input  logic           RST,   // synchronous, active-low
    sys_ctrl_rec_if.slave  bus
);

    rec_state_e            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic                  wr_en_q,    wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
    logic                  rd_en_q,    rd_en_d;
    logic                  alu_en_q,   alu_en_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q,  alu_fun_d;
    logic                  clk_en_q,   clk_en_d;
    logic                  send_en_q,  send_en_d;

    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_vld;
    logic                  alu_done;

    assign rx_byte  = bus.RX_P_DATA;
    assign rx_vld   = bus.RX_D_VLD;
    assign alu_done = bus.alu_out_done;

    // Next state and next output values; strobes default low, levels hold
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
        clk_en_d  = clk_en_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        send_en_d = 1'b0;

        case (state_q)
            REC_IDLE: begin
                // Unknown opcodes are silently discarded
                if (rx_vld) begin
                    if (rx_byte == DATA_WIDTH'(CMD_WR)) begin
                        state_d = REC_WR_ADDR;
                    end else if (rx_byte == DATA_WIDTH'(CMD_RD)) begin
                        state_d = REC_RD_ADDR;
                    end else if (rx_byte == DATA_WIDTH'(CMD_ALU_OP)) begin
                        state_d = REC_OP_A;
                    end else if (rx_byte == DATA_WIDTH'(CMD_ALU_NOP)) begin
                        state_d = REC_ALU_FUN;
                    end
                end
            end

            REC_WR_ADDR: begin
                if (rx_vld) begin
                    addr_d  = rx_byte[ADDR_WIDTH-1:0];
                    state_d = REC_WR_DATA;
                end
            end

            REC_WR_DATA: begin
                if (rx_vld) begin
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    state_d   = REC_IDLE;
                end
            end

            REC_RD_ADDR: begin
                // The read data goes straight back out through sys_ctrl_send
                if (rx_vld) begin
                    addr_d    = rx_byte[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    send_en_d = 1'b1;
                    state_d   = REC_IDLE;
                end
            end

            REC_OP_A: begin
                if (rx_vld) begin
                    addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    state_d   = REC_OP_B;
                end
            end

            REC_OP_B: begin
                if (rx_vld) begin
                    addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    state_d   = REC_ALU_FUN;
                end
            end

            REC_ALU_FUN: begin
                // Ungate the ALU clock together with the start strobe
                if (rx_vld) begin
                    alu_fun_d = rx_byte[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    send_en_d = 1'b1;
                    clk_en_d  = 1'b1;
                    state_d   = REC_ALU_WAIT;
                end
            end

            REC_ALU_WAIT: begin
                // Bytes arriving here are dropped; only the send side can
                // release us, and it does so even if a byte arrives together
                clk_en_d = 1'b1;
                if (alu_done) begin
                    clk_en_d = 1'b0;
                    state_d  = REC_IDLE;
                end
            end

            default: begin
                state_d = REC_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= REC_IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            clk_en_q  <= 1'b0;
            send_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            alu_fun_q <= alu_fun_d;
            clk_en_q  <= clk_en_d;
            send_en_q <= send_en_d;
        end
    end

    assign bus.Address          = addr_q;
    assign bus.WrEn             = wr_en_q;
    assign bus.WrData           = wr_data_q;
    assign bus.RdEn             = rd_en_q;
    assign bus.ALU_EN           = alu_en_q;
    assign bus.ALU_FUN          = alu_fun_q;
    assign bus.CLK_EN           = clk_en_q;
    assign bus.sys_ctrl_send_en = send_en_q;

endmodule : sys_ctrl_rec
`default_nettype wire
